bram_arbiter: RTL and testbench

Two-requester round-robin arbiter in front of one single-port `bram` instance. Each requester has its own valid/ready command channel and read-return channel. The arbiter grants at most one access per clock to the shared RAM and returns read data one cycle after the grant. It sits between two independent datapath clients, for example a writer engine and a readout engine, and the on-chip buffer they share.

---
 rtl/bram_arb_pkg.sv | 19 +
 rtl/bram.sv | 35 +++
 rtl/bram_arbiter.sv | 136 +++++++++++++
 tb/tb_bram_arbiter.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bram_arb_pkg.sv
// Shared definitions for the two-requester BRAM arbiter.
// Holds the grant index constants, the default RAM geometry and the command
// payload struct used to carry one requester's command through the mux.
package bram_arb_pkg;

    localparam int unsigned ARB_DATA_W = 8;
    localparam int unsigned ARB_ADDR_W = 8;

    localparam logic REQ0 = 1'b0;
    localparam logic REQ1 = 1'b1;

    // One requester command as presented to the shared RAM.
    typedef struct packed {
        logic                  write;
        logic [ARB_ADDR_W-1:0] address;
        logic [ARB_DATA_W-1:0] wdata;
    } arb_cmd_t;

endpackage

// File: rtl/bram.sv
// Single-port, read-first block RAM with clock enable.
// Ports:
//   clock        rising-edge clock
//   ram_enable   access enable; no state changes when low
//   write_enable 1 = write input_data to address (old word still read out)
//   address      word address
//   input_data   write data
//   output_data  registered read data; no reset, undefined until first access
module bram #(
    parameter int unsigned RAM_WIDTH     = 8,
    parameter int unsigned RAM_ADDR_BITS = 8
) (
    input  logic                     clock,
    input  logic                     ram_enable,
    input  logic                     write_enable,
    input  logic [RAM_ADDR_BITS-1:0] address,
    input  logic [RAM_WIDTH-1:0]     input_data,
    output logic [RAM_WIDTH-1:0]     output_data
);

    localparam int unsigned DEPTH = 1 << RAM_ADDR_BITS;

    logic [RAM_WIDTH-1:0] mem [DEPTH];

    // Read-first: output_data captures the word before any write lands.
    always_ff @(posedge clock) begin
        if (ram_enable) begin
            if (write_enable) begin
                mem[address] <= input_data;
            end
            output_data <= mem[address];
        end
    end

endmodule

// File: rtl/bram_arbiter.sv
// Two-requester round-robin arbiter in front of one single-port bram.
// Ports:
//   clock, reset_n          clock and asynchronous active-low reset
//   reqN_valid/write        command present / 1 = write
//   reqN_address/wdata      command fields, held stable while waiting
//   reqN_ready              combinational grant for requester N
//   reqN_rvalid/rdata       read return, one cycle after an accepted read
module bram_arbiter
    import bram_arb_pkg::*;
#(
    parameter int unsigned RAM_WIDTH     = ARB_DATA_W,
    parameter int unsigned RAM_ADDR_BITS = ARB_ADDR_W
) (
    input  logic                     clock,
    input  logic                     reset_n,

    input  logic                     req0_valid,
    input  logic                     req0_write,
    input  logic [RAM_ADDR_BITS-1:0] req0_address,
    input  logic [RAM_WIDTH-1:0]     req0_wdata,
    output logic                     req0_ready,
    output logic                     req0_rvalid,
    output logic [RAM_WIDTH-1:0]     req0_rdata,

    input  logic                     req1_valid,
    input  logic                     req1_write,
    input  logic [RAM_ADDR_BITS-1:0] req1_address,
    input  logic [RAM_WIDTH-1:0]     req1_wdata,
    output logic                     req1_ready,
    output logic                     req1_rvalid,
    output logic [RAM_WIDTH-1:0]     req1_rdata
);

    logic       last_grant;
    logic [1:0] rd_pend;

    logic       grant0_c;
    logic       grant1_c;

    arb_cmd_t   cmd0_c;
    arb_cmd_t   cmd1_c;
    arb_cmd_t   sel_cmd_c;

    logic                     ram_enable_c;
    logic                     write_enable_c;
    logic [RAM_ADDR_BITS-1:0] address_c;
    logic [RAM_WIDTH-1:0]     input_data_c;
    logic [RAM_WIDTH-1:0]     output_data;

    // Grant: a lone requester always wins; on contention the one that did
    // not win last time gets the RAM.
    always_comb begin
        grant0_c = 1'b0;
        grant1_c = 1'b0;
        if (req0_valid && req1_valid) begin
            if (last_grant == REQ1) begin
                grant0_c = 1'b1;
            end else begin
                grant1_c = 1'b1;
            end
        end else begin
            grant0_c = req0_valid;
            grant1_c = req1_valid;
        end
    end

    // Pack each requester's command into the shared payload format.
    always_comb begin
        cmd0_c = '{write:   req0_write,
                   address: ARB_ADDR_W'(req0_address),
                   wdata:   ARB_DATA_W'(req0_wdata)};
        cmd1_c = '{write:   req1_write,
                   address: ARB_ADDR_W'(req1_address),
                   wdata:   ARB_DATA_W'(req1_wdata)};
    end

    // RAM-side mux; address/data are forced to 0 on idle cycles.
    always_comb begin
        sel_cmd_c      = '0;
        ram_enable_c   = 1'b0;
        write_enable_c = 1'b0;
        address_c      = '0;
        input_data_c   = '0;
        if (grant0_c) begin
            sel_cmd_c = cmd0_c;
        end else if (grant1_c) begin
            sel_cmd_c = cmd1_c;
        end
        if (grant0_c || grant1_c) begin
            ram_enable_c   = 1'b1;
            write_enable_c = sel_cmd_c.write;
            address_c      = RAM_ADDR_BITS'(sel_cmd_c.address);
            input_data_c   = RAM_WIDTH'(sel_cmd_c.wdata);
        end
    end

    // Priority state: remembers the most recent winner, held while idle.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            last_grant <= REQ1;
        end else if (grant1_c) begin
            last_grant <= REQ1;
        end else if (grant0_c) begin
            last_grant <= REQ0;
        end
    end

    // Read return tags: marks which requester owns next cycle's output_data.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rd_pend <= 2'b00;
        end else begin
            rd_pend <= {grant1_c & ~req1_write, grant0_c & ~req0_write};
        end
    end

    assign req0_ready  = grant0_c;
    assign req1_ready  = grant1_c;
    assign req0_rvalid = rd_pend[0];
    assign req1_rvalid = rd_pend[1];
    assign req0_rdata  = output_data;
    assign req1_rdata  = output_data;

    bram #(
        .RAM_WIDTH     (RAM_WIDTH),
        .RAM_ADDR_BITS (RAM_ADDR_BITS)
    ) u_ram (
        .clock        (clock),
        .ram_enable   (ram_enable_c),
        .write_enable (write_enable_c),
        .address      (address_c),
        .input_data   (input_data_c),
        .output_data  (output_data)
    );

endmodule

// File: tb/tb_bram_arbiter.sv
// Self-checking bench for bram_arbiter against a behavioural model of the
// shared memory, the round-robin rule and the one-cycle read return.
module tb_bram_arbiter;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       req0_valid, req0_write, req0_ready, req0_rvalid;
    logic [7:0] req0_address, req0_wdata, req0_rdata;
    logic       req1_valid, req1_write, req1_ready, req1_rvalid;
    logic [7:0] req1_address, req1_wdata, req1_rdata;

    int checks   = 0;
    int failures = 0;

    // Reference model state.
    logic [7:0] m_mem   [256];
    bit         m_known [256];
    bit         m_last;

    // Per-cycle expected and observed values.
    bit         e_g0, e_g1, exp_rv0, exp_rv1, known0, known1;
    logic [7:0] exp_rd0, exp_rd1;
    logic       obs_rdy0, obs_rdy1, obs_rv0, obs_rv1;
    logic [7:0] obs_rd0, obs_rd1;

    always #5 clock = ~clock;

    bram_arbiter #(.RAM_WIDTH(8), .RAM_ADDR_BITS(8)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .req0_valid   (req0_valid),
        .req0_write   (req0_write),
        .req0_address (req0_address),
        .req0_wdata   (req0_wdata),
        .req0_ready   (req0_ready),
        .req0_rvalid  (req0_rvalid),
        .req0_rdata   (req0_rdata),
        .req1_valid   (req1_valid),
        .req1_write   (req1_write),
        .req1_address (req1_address),
        .req1_wdata   (req1_wdata),
        .req1_ready   (req1_ready),
        .req1_rvalid  (req1_rvalid),
        .req1_rdata   (req1_rdata)
    );

    // Drive one cycle of commands (called just after a falling edge), sample
    // ready before the rising edge, advance the model, then sample the return.
    task automatic run_cycle(input logic v0, input logic w0, input logic [7:0] a0, input logic [7:0] d0,
                             input logic v1, input logic w1, input logic [7:0] a1, input logic [7:0] d1);
        req0_valid = v0; req0_write = w0; req0_address = a0; req0_wdata = d0;
        req1_valid = v1; req1_write = w1; req1_address = a1; req1_wdata = d1;
        #1;
        if (v0 && v1) begin
            e_g0 = (m_last == 1'b1);
            e_g1 = !e_g0;
        end else begin
            e_g0 = v0;
            e_g1 = v1;
        end
        obs_rdy0 = req0_ready;
        obs_rdy1 = req1_ready;
        @(posedge clock);
        exp_rv0 = e_g0 && !w0;
        exp_rv1 = e_g1 && !w1;
        exp_rd0 = m_mem[a0]; known0 = m_known[a0];
        exp_rd1 = m_mem[a1]; known1 = m_known[a1];
        if (e_g0 && w0) begin m_mem[a0] = d0; m_known[a0] = 1'b1; end
        if (e_g1 && w1) begin m_mem[a1] = d1; m_known[a1] = 1'b1; end
        if (e_g1) m_last = 1'b1;
        else if (e_g0) m_last = 1'b0;
        #1;
        obs_rv0 = req0_rvalid; obs_rd0 = req0_rdata;
        obs_rv1 = req1_rvalid; obs_rd1 = req1_rdata;
        @(negedge clock);
    endtask

    task automatic idle_inputs();
        req0_valid = 0; req0_write = 0; req0_address = 0; req0_wdata = 0;
        req1_valid = 0; req1_write = 0; req1_address = 0; req1_wdata = 0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        reset_n = 1'b0;
        @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        m_last = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        req0_valid = 1; req0_write = 0; req0_address = 8'h05; req0_wdata = 0;
        req1_valid = 1; req1_write = 0; req1_address = 8'h06; req1_wdata = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
                failures++;
                $display("FAIL reset_ready: got %b%b want 10", req0_ready, req1_ready);
            end
            @(posedge clock); #1;
            checks++;
            if (req0_rvalid !== 1'b0 || req1_rvalid !== 1'b0) begin
                failures++;
                $display("FAIL reset_rvalid: got %b%b want 00", req0_rvalid, req1_rvalid);
            end
            @(negedge clock);
        end
        reset_n = 1'b1;
        m_last = 1'b1;
        run_cycle(1, 0, 8'h05, 0, 1, 0, 8'h06, 0);
        checks++;
        if (obs_rdy0 !== 1'b1 || obs_rdy1 !== 1'b0) begin
            failures++;
            $display("FAIL reset_first_grant: got %b%b want 10", obs_rdy0, obs_rdy1);
        end
        checks++;
        if (obs_rv0 !== 1'b1 || obs_rv1 !== 1'b0) begin
            failures++;
            $display("FAIL reset_first_rvalid: got %b%b want 10", obs_rv0, obs_rv1);
        end
        idle_inputs();
    endtask

    task automatic test_single();
        run_cycle(1, 1, 8'h10, 8'hA5, 0, 0, 0, 0);
        checks++;
        if (obs_rdy0 !== 1'b1 || obs_rv0 !== 1'b0 || obs_rv1 !== 1'b0) begin
            failures++;
            $display("FAIL single_write: ready=%b rvalid=%b%b want 1 00", obs_rdy0, obs_rv0, obs_rv1);
        end
        run_cycle(1, 0, 8'h10, 0, 0, 0, 0, 0);
        checks++;
        if (obs_rv0 !== 1'b1 || obs_rv1 !== 1'b0 || obs_rd0 !== 8'hA5) begin
            failures++;
            $display("FAIL single_read: rvalid=%b%b rdata=%h want 10 a5", obs_rv0, obs_rv1, obs_rd0);
        end
        run_cycle(0, 0, 0, 0, 0, 0, 0, 0);
        checks++;
        if (obs_rv0 !== 1'b0 || obs_rv1 !== 1'b0) begin
            failures++;
            $display("FAIL single_drop: rvalid=%b%b want 00", obs_rv0, obs_rv1);
        end
    endtask

    task automatic test_contention();
        run_cycle(1, 1, 8'h01, 8'h11, 0, 0, 0, 0);
        run_cycle(0, 0, 0, 0, 1, 1, 8'h02, 8'h22);
        apply_reset();
        for (int i = 0; i < 8; i++) begin
            run_cycle(1, 0, 8'h01, 0, 1, 0, 8'h02, 0);
            checks++;
            if (obs_rdy0 !== ((i % 2) == 0) || obs_rdy1 !== ((i % 2) == 1)) begin
                failures++;
                $display("FAIL contention_grant[%0d]: got %b%b want %b%b", i, obs_rdy0, obs_rdy1,
                         (i % 2) == 0, (i % 2) == 1);
            end
            checks++;
            if ((i % 2) == 0 ? (obs_rv0 !== 1'b1 || obs_rv1 !== 1'b0 || obs_rd0 !== 8'h11)
                             : (obs_rv0 !== 1'b0 || obs_rv1 !== 1'b1 || obs_rd1 !== 8'h22)) begin
                failures++;
                $display("FAIL contention_data[%0d]: rvalid=%b%b rdata0=%h rdata1=%h want %s", i,
                         obs_rv0, obs_rv1, obs_rd0, obs_rd1, (i % 2) == 0 ? "10 11" : "01 22");
            end
        end
        idle_inputs();
    endtask

    task automatic test_collision();
        bit r_first;
        run_cycle(1, 1, 8'h20, 8'h77, 0, 0, 0, 0);
        run_cycle(1, 0, 8'h20, 0, 1, 1, 8'h20, 8'h3C);
        r_first = e_g0;
        checks++;
        if (obs_rdy0 !== e_g0 || obs_rdy1 !== e_g1 || obs_rv0 !== exp_rv0 || obs_rv1 !== exp_rv1) begin
            failures++;
            $display("FAIL collision_first: ready=%b%b rvalid=%b%b want %b%b %b%b", obs_rdy0, obs_rdy1,
                     obs_rv0, obs_rv1, e_g0, e_g1, exp_rv0, exp_rv1);
        end
        if (r_first) begin
            checks++;
            if (obs_rd0 !== 8'h77) begin
                failures++;
                $display("FAIL collision_old: rdata=%h want 77", obs_rd0);
            end
            run_cycle(0, 0, 0, 0, 1, 1, 8'h20, 8'h3C);
        end else begin
            run_cycle(1, 0, 8'h20, 0, 0, 0, 0, 0);
            checks++;
            if (obs_rv0 !== 1'b1 || obs_rd0 !== 8'h3C) begin
                failures++;
                $display("FAIL collision_new: rvalid=%b rdata=%h want 1 3c", obs_rv0, obs_rd0);
            end
        end
        run_cycle(1, 0, 8'h20, 0, 0, 0, 0, 0);
        checks++;
        if (obs_rv0 !== 1'b1 || obs_rd0 !== 8'h3C) begin
            failures++;
            $display("FAIL collision_after: rvalid=%b rdata=%h want 1 3c", obs_rv0, obs_rd0);
        end
    endtask

    task automatic test_back_to_back();
        int bad_rdy = 0;
        int bad_rd  = 0;
        for (int a = 0; a < 256; a++) begin
            run_cycle(0, 0, 0, 0, 1, 1, 8'(a), 8'(a));
            checks++;
            if (obs_rdy1 !== 1'b1 || obs_rdy0 !== 1'b0 || obs_rv1 !== 1'b0) begin
                failures++; bad_rdy++;
                if (bad_rdy < 4)
                    $display("FAIL b2b_write[%0d]: ready=%b%b rvalid1=%b want 01 0", a, obs_rdy0, obs_rdy1, obs_rv1);
            end
        end
        for (int a = 0; a < 256; a++) begin
            run_cycle(1, 0, 8'(a), 0, 0, 0, 0, 0);
            checks++;
            if (obs_rdy0 !== 1'b1 || obs_rv0 !== 1'b1 || obs_rv1 !== 1'b0 || obs_rd0 !== 8'(a)) begin
                failures++; bad_rd++;
                if (bad_rd < 4)
                    $display("FAIL b2b_read[%0d]: ready=%b rvalid=%b%b rdata=%h want 1 10 %h", a,
                             obs_rdy0, obs_rv0, obs_rv1, obs_rd0, 8'(a));
            end
        end
        idle_inputs();
    endtask

    task automatic test_random();
        logic v0 = 0, w0 = 0, v1 = 0, w1 = 0;
        logic [7:0] a0 = 0, d0 = 0, a1 = 0, d1 = 0;
        int bad = 0;
        for (int i = 0; i < 300; i++) begin
            // A waiting requester must hold its command; otherwise pick anew.
            if (!(v0 && !e_g0) || i == 0) begin
                v0 = 1'($urandom_range(0, 3) != 0); w0 = 1'($urandom);
                a0 = 8'($urandom); d0 = 8'($urandom);
            end
            if (!(v1 && !e_g1) || i == 0) begin
                v1 = 1'($urandom_range(0, 3) != 0); w1 = 1'($urandom);
                a1 = 8'($urandom); d1 = 8'($urandom);
            end
            run_cycle(v0, w0, a0, d0, v1, w1, a1, d1);
            checks++;
            if (obs_rdy0 !== e_g0 || obs_rdy1 !== e_g1 || obs_rv0 !== exp_rv0 || obs_rv1 !== exp_rv1 ||
                (exp_rv0 && known0 && obs_rd0 !== exp_rd0) || (exp_rv1 && known1 && obs_rd1 !== exp_rd1)) begin
                failures++; bad++;
                if (bad < 6)
                    $display("FAIL random[%0d]: ready=%b%b rvalid=%b%b rdata=%h/%h want %b%b %b%b %h/%h", i,
                             obs_rdy0, obs_rdy1, obs_rv0, obs_rv1, obs_rd0, obs_rd1,
                             e_g0, e_g1, exp_rv0, exp_rv1, exp_rd0, exp_rd1);
            end
        end
        idle_inputs();
    endtask

    task automatic test_reset_mid_read();
        run_cycle(1, 0, 8'h10, 0, 0, 0, 0, 0);
        // last winner is now req0; reset must restore req0 priority.
        req0_valid = 1; req0_write = 0; req0_address = 8'h11; req0_wdata = 0;
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (req0_rvalid !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_async: rvalid0=%b want 0", req0_rvalid);
        end
        @(posedge clock); #1;
        checks++;
        if (req0_rvalid !== 1'b0 || req1_rvalid !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_rvalid: rvalid=%b%b want 00", req0_rvalid, req1_rvalid);
        end
        @(negedge clock);
        idle_inputs();
        reset_n = 1'b1;
        m_last = 1'b1;
        run_cycle(0, 0, 0, 0, 0, 0, 0, 0);
        checks++;
        if (obs_rv0 !== 1'b0 || obs_rv1 !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_release: rvalid=%b%b want 00", obs_rv0, obs_rv1);
        end
        run_cycle(1, 0, 8'h11, 0, 1, 0, 8'h12, 0);
        checks++;
        if (obs_rdy0 !== 1'b1 || obs_rdy1 !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_priority: got %b%b want 10", obs_rdy0, obs_rdy1);
        end
        idle_inputs();
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            m_mem[i] = 8'h00;
            m_known[i] = 1'b0;
        end
        m_last = 1'b1;
        e_g0 = 0; e_g1 = 0;
        idle_inputs();
        reset_n = 1'b0;
        @(negedge clock);
        test_reset();
        test_single();
        test_contention();
        test_collision();
        test_back_to_back();
        test_random();
        test_reset_mid_read();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
